// File: rtl/cpu_dmem_ctrl.sv
// Data-memory controller: valid/ready requests into an inferred single-port RAM, registered responses.
// Byte-enable read-modify-write is built only when CPU_DMEM_BYTE_WRITE_EN is defined.
module cpu_dmem_ctrl #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 32,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                dbg_state
);

  // Handshake: a request is taken on a rising edge with req_valid && req_ready; the
  // response side has no backpressure and rsp_valid is a one-cycle strobe, in request order.

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  ram_idx;
  logic              in_range;
  logic              accept;
  logic              do_read;
  logic              do_full_wr;
  logic              do_part;

  assign accept   = req_valid && req_ready;
  assign word_idx = req_addr >> OFF_W;
  assign in_range = word_idx < ADDR_W'(DEPTH);
  assign ram_idx  = word_idx[IDX_W-1:0];
  assign do_read  = accept && !req_write && in_range;
  assign dbg_state = state;

`ifdef CPU_DMEM_BYTE_WRITE_EN
  logic              full_be;
  logic              zero_be;
  logic [IDX_W-1:0]  m_idx;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_old;
  logic [NB-1:0]     m_be;
  logic [DATA_W-1:0] merged;

  assign full_be    = &req_be;
  assign zero_be    = ~|req_be;
  assign do_full_wr = accept && req_write && in_range && full_be;
  assign do_part    = accept && req_write && in_range && !full_be && !zero_be;

  // The old word is captured at the accept edge and merged during MERGE.
  always_ff @(posedge clk) begin
    if (do_part) begin
      m_idx   <= ram_idx;
      m_wdata <= req_wdata;
      m_be    <= req_be;
      m_old   <= mem[ram_idx];
    end
  end

  always_comb begin
    merged = m_old;
    for (int b = 0; b < NB; b++) begin
      if (m_be[b]) merged[8*b +: 8] = m_wdata[8*b +: 8];
    end
  end
`else
  logic unused_be;

  assign unused_be  = ^req_be;
  assign do_full_wr = accept && req_write && in_range;
  assign do_part    = 1'b0;
`endif

  // An async reset during MERGE drops state to IDLE, so the pending merge write never lands.
  always_ff @(posedge clk) begin
    if (do_full_wr) begin
      mem[ram_idx] <= req_wdata;
    end
`ifdef CPU_DMEM_BYTE_WRITE_EN
    else if (state == MERGE) begin
      mem[m_idx] <= merged;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            if (!in_range) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (do_read) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= mem[ram_idx];
            end else if (do_part) begin
              state     <= MERGE;
              req_ready <= 1'b0;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        MERGE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_dmem_ctrl.sv
// Self-checking bench for cpu_dmem_ctrl: directed cases plus random traffic against a
// word-array reference model, with a scoreboard that also checks response timing.
module tb_cpu_dmem_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 32;
  localparam int NB     = DATA_W / 8;
  localparam int EXP_W  = 1 + DATA_W + 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [NB-1:0]     req_be = '0;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              dbg_state;

  cpu_dmem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [EXP_W-1:0]  exp_q [$];
  logic [DATA_W-1:0] hold_exp = '0;

`ifdef CPU_DMEM_BYTE_WRITE_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory as an array of words, bytes updated lane by lane.
  function automatic void model_access(input logic w, input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] wd, input logic [NB-1:0] be,
                                       output logic err, output logic [DATA_W-1:0] rd,
                                       output int lat);
    logic [ADDR_W-1:0] word;
    word = addr / NB;
    err  = 1'b0;
    rd   = '0;
    lat  = 1;
    if (word >= DEPTH) begin
      err = 1'b1;
    end else if (!w) begin
      rd = model_mem[word];
    end else if (RMW) begin
      if (be != '0 && be != '1) lat = 2;
      for (int b = 0; b < NB; b++) begin
        if (be[b]) model_mem[word][8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      model_mem[word] = wd;
    end
  endfunction

  // ---------------- driver tasks (called on a falling edge) ----------------
  task automatic do_req(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    logic              err;
    logic [DATA_W-1:0] rd;
    int                lat;
    int                waited;
    waited    = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got req_ready=0 for %0d cycles, expected 1", waited);
      req_valid = 1'b0;
      return;
    end
    model_access(w, a, d, be, err, rd, lat);
    exp_q.push_back({err, rd, cyc + 32'(lat)});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int waited;
    waited    = 0;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!reset) begin
      hold_exp = '0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%0h err=%0b, expected no response",
                 rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", 64'(rsp_err), 64'(e[EXP_W-1]));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e[EXP_W-2 -: DATA_W]));
        check("rsp_cycle", 64'(cyc), 64'(e[31:0]));
        hold_exp = e[EXP_W-2 -: DATA_W];
      end
    end else begin
      check("rdata_hold", 64'(rsp_rdata), 64'(hold_exp));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    foreach (model_mem[i]) model_mem[i] = '0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Preload every word: 1,2,3,4 in words 0..3, 0x11223344 at 0x20, random elsewhere.
    for (int i = 0; i < DEPTH; i++) begin
      logic [DATA_W-1:0] v;
      if (i < 4)       v = DATA_W'(i + 1);
      else if (i == 8) v = 32'h1122_3344;
      else             v = $urandom;
      do_req(1'b1, ADDR_W'(i * NB), v, '1);
    end

    // Full write then read back.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_req(1'b0, 32'h10, '0, '0);

    // Partial write: one-cycle ready drop and MERGE only when RMW is built.
    do_req(1'b1, 32'h10, 32'h0000_00AA, 4'h1);
    check("merge_ready", 64'(req_ready), RMW ? 64'd0 : 64'd1);
    check("merge_state", 64'(dbg_state), RMW ? 64'd1 : 64'd0);
    do_req(1'b0, 32'h10, '0, '0);

    // Out-of-range read and write; word 0 must be untouched.
    do_req(1'b0, 32'h80, '0, '0);
    do_req(1'b1, 32'h80, 32'hBAD0_BAD0, 4'hF);
    do_req(1'b0, 32'h00, '0, '0);

    // Back-to-back reads of the preloaded words.
    do_req(1'b0, 32'h00, '0, '0);
    do_req(1'b0, 32'h04, '0, '0);
    do_req(1'b0, 32'h08, '0, '0);
    do_req(1'b0, 32'h0C, '0, '0);

    // Write with no byte enables.
    do_req(1'b1, 32'h04, 32'hFFFF_FFFF, 4'h0);
    do_req(1'b0, 32'h04, '0, '0);
    drain();

    // Reset pulsed during MERGE: outputs clear at once, no response, word keeps old value.
    check("pre_merge_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hA5A5_A5A5;
    req_be    = 4'h3;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    reset     = 1'b0;
    if (!RMW) model_mem[8] = 32'hA5A5_A5A5;
    #1;
    check("async_ready", 64'(req_ready), 64'd0);
    check("async_valid", 64'(rsp_valid), 64'd0);
    check("async_err", 64'(rsp_err), 64'd0);
    check("async_rdata", 64'(rsp_rdata), 64'd0);
    check("async_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h20, '0, '0);

    // Random traffic, including out-of-range words and ignored low address bits.
    for (int n = 0; n < 300; n++) begin
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [NB-1:0]     be;
      int                sel;
      w   = 1'($urandom_range(0, 1));
      a   = ADDR_W'($urandom_range(0, DEPTH + 8) * NB + $urandom_range(0, NB - 1));
      sel = $urandom_range(0, 3);
      if (sel == 0)      be = '1;
      else if (sel == 1) be = '0;
      else               be = NB'($urandom_range(1, (1 << NB) - 2));
      do_req(w, a, $urandom, be);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
